// File: rtl/rmii_rx_deframe_pkg.sv
// Shared constants, FSM state encodings and a width helper for the RMII
// receive deframer.
package rmii_rx_deframe_pkg;

  localparam int BYTE_LEN = 8;

  localparam logic [1:0] RMII_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] RMII_SFD_DIBIT      = 2'b11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_PREAMBLE = ST_PREAMBLE,
    S_DATA     = ST_DATA,
    S_DROP     = ST_DROP
  } rx_state_e;

  // Bits needed to hold values 0..v-1; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rmii_rx_deframe_crsdv_hold.sv
// One-dibit hold slot. A held dibit is only judged once the following
// sample is visible, so the low phase of the end-of-frame CRS_DV toggle
// still counts as data while two consecutive lows mark the real end.
module rmii_crsdv_hold (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_crsdv,
  input  logic [1:0] i_rxd,
  output logic [1:0] o_dibit,
  output logic       o_valid,
  output logic       o_eof
);

  logic       r_full;
  logic       r_crsdv;
  logic [1:0] r_rxd;

  // Load the current sample every enabled cycle; empty the slot otherwise.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_full  <= 1'b0;
      r_crsdv <= 1'b0;
      r_rxd   <= 2'b00;
    end else begin
      r_full  <= 1'b1;
      r_crsdv <= i_crsdv;
      r_rxd   <= i_rxd;
    end
  end

  assign o_dibit = r_rxd;
  assign o_valid = i_en & r_full & (r_crsdv | i_crsdv);
  assign o_eof   = i_en & r_full & ~r_crsdv & ~i_crsdv;

endmodule

// File: rtl/rmii_rx_deframe.sv
// RMII receive deframer: strips preamble/SFD, emits payload+FCS dibits as
// a strobe stream, then a done pulse with an error flag.
// Optional macro RMII_RX_ERR_EN adds the rxer input (RMII RX_ER).
module rmii_rx_deframe
  import rmii_rx_deframe_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 12,
  parameter int MAX_FRAME_BYTES     = 1522
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       crsdv,
  input  logic [1:0] rxd,
`ifdef RMII_RX_ERR_EN
  input  logic       rxer,
`endif
  output logic [1:0] out,
  output logic       outclk,
  output logic       done_out,
  output logic       err
);

  localparam int DMAX_I = (BYTE_LEN / 2) * MAX_FRAME_BYTES;
  localparam int DW     = clog2(DMAX_I + 1);
  localparam int PCW    = clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam logic [DW-1:0]  DMAX = DW'(DMAX_I);
  localparam logic [PCW-1:0] PMIN = PCW'(MIN_PREAMBLE_DIBITS);

  rx_state_e      r_state;
  logic           r_prev_crsdv;
  logic [PCW-1:0] r_pcnt;
  logic [DW-1:0]  r_dcnt;
  logic           r_bad;
  logic [1:0]     r_out;
  logic           r_outclk;
  logic           r_done;
  logic           r_err;

  logic [1:0] w_dibit;
  logic       w_valid;
  logic       w_eof;
  logic       w_two_lows;
  logic       w_rxer;

`ifdef RMII_RX_ERR_EN
  assign w_rxer = rxer;
`else
  assign w_rxer = 1'b0;
`endif

  assign w_two_lows = ~crsdv & ~r_prev_crsdv;

  rmii_crsdv_hold u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_en    (r_state == S_DATA),
    .i_crsdv (crsdv),
    .i_rxd   (rxd),
    .o_dibit (w_dibit),
    .o_valid (w_valid),
    .o_eof   (w_eof)
  );

  // Frame FSM with registered strobe, done and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prev_crsdv <= 1'b1;
      r_pcnt       <= '0;
      r_dcnt       <= '0;
      r_bad        <= 1'b0;
      r_out        <= 2'b00;
      r_outclk     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_prev_crsdv <= crsdv;
      r_outclk     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (crsdv && !r_prev_crsdv) begin
            r_state <= S_PREAMBLE;
            r_pcnt  <= '0;
          end
        end
        S_PREAMBLE: begin
          if (w_two_lows) begin
            r_state <= S_IDLE;
          end else if (w_rxer) begin
            r_state <= S_DROP;
          end else begin
            case (rxd)
              RMII_PREAMBLE_DIBIT: begin
                if (r_pcnt != {PCW{1'b1}}) r_pcnt <= r_pcnt + 1'b1;
              end
              RMII_SFD_DIBIT: begin
                if (r_pcnt >= PMIN) begin
                  r_state <= S_DATA;
                  r_dcnt  <= '0;
                  r_bad   <= 1'b0;
                end else begin
                  r_state <= S_DROP;
                end
              end
              2'b00: begin
                // Idle dibits are tolerated only before the preamble starts.
                if (r_pcnt != '0) r_state <= S_DROP;
              end
              default: r_state <= S_DROP;
            endcase
          end
        end
        S_DATA: begin
          if (w_rxer) r_bad <= 1'b1;
          if (w_eof) begin
            r_done  <= 1'b1;
            r_err   <= (r_dcnt[1:0] != 2'b00) | r_bad | w_rxer;
            r_state <= S_IDLE;
          end else if (w_valid) begin
            if (r_dcnt == DMAX) begin
              // Oversize: suppress this dibit and close the frame as bad.
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_DROP;
            end else begin
              r_out    <= w_dibit;
              r_outclk <= 1'b1;
              r_dcnt   <= r_dcnt + 1'b1;
            end
          end
        end
        S_DROP: begin
          if (w_two_lows) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out      = r_out;
  assign outclk   = r_outclk;
  assign done_out = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_rmii_rx_deframe.sv
// Directed bench for rmii_rx_deframe: a default instance and a
// MAX_FRAME_BYTES=4 instance share stimulus; negedge monitors record output.
module tb_rmii_rx_deframe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       rxer = 1'b0;

  logic [1:0] out, out4;
  logic       outclk, outclk4, done_out, done_out4, err, err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rmii_rx_deframe #(.MIN_PREAMBLE_DIBITS(12), .MAX_FRAME_BYTES(1522)) dut (
    .clk(clk), .reset(reset), .crsdv(crsdv), .rxd(rxd),
`ifdef RMII_RX_ERR_EN
    .rxer(rxer),
`endif
    .out(out), .outclk(outclk), .done_out(done_out), .err(err)
  );

  rmii_rx_deframe #(.MIN_PREAMBLE_DIBITS(12), .MAX_FRAME_BYTES(4)) dut4 (
    .clk(clk), .reset(reset), .crsdv(crsdv), .rxd(rxd),
`ifdef RMII_RX_ERR_EN
    .rxer(rxer),
`endif
    .out(out4), .outclk(outclk4), .done_out(done_out4), .err(err4)
  );

  // Monitor state
  int         ncyc = 0;
  logic [1:0] cap [0:63];
  int         cnt = 0, ndone = 0, last_oc = 0, done_cyc = 0;
  logic       done_err = 1'b0;
  int         cnt4 = 0, ndone4 = 0, last_oc4 = 0, done_cyc4 = 0;
  logic       done_err4 = 1'b0;
  logic [1:0] exp_d [0:63];

  // Sample outputs mid-cycle; also flag any strobe/done overlap.
  always @(negedge clk) begin
    ncyc++;
    if (outclk) begin
      if (cnt < 64) cap[cnt] = out;
      cnt++;
      last_oc = ncyc;
    end
    if (done_out) begin
      ndone++;
      done_err = err;
      done_cyc = ncyc;
      checks++;
      if (outclk) begin
        errors++;
        $display("FAIL overlap: outclk=%0b with done_out, required 0", outclk);
      end
    end
    if (outclk4) begin
      cnt4++;
      last_oc4 = ncyc;
    end
    if (done_out4) begin
      ndone4++;
      done_err4 = err4;
      done_cyc4 = ncyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test sequence");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic c, input logic [1:0] d);
    @(negedge clk);
    crsdv = c;
    rxd   = d;
  endtask

  task automatic preamble(input int n);
    repeat (n) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
  endtask

  task automatic gap(input int n);
    repeat (n) send(1'b0, 2'b00);
  endtask

  task automatic clr_mon();
    #1;
    cnt = 0; ndone = 0; done_err = 1'b0;
    cnt4 = 0; ndone4 = 0; done_err4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL rst_out: got %0h want 0", out); end
    checks++; if (outclk !== 1'b0) begin errors++; $display("FAIL rst_outclk: got %0b want 0", outclk); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_clean_frame();
    logic [7:0] b [0:7];
    logic [7:0] got;
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 32; i++) exp_d[i] = b[i/4][2*(i%4) +: 2];
    gap(3);
    clr_mon();
    preamble(28);
    for (int i = 0; i < 32; i++) send(1'b1, exp_d[i]);
    gap(5);
    checks++; if (cnt !== 32) begin errors++; $display("FAIL clean_count: got %0d want 32", cnt); end
    for (int k = 0; k < 8; k++) begin
      got = {cap[4*k+3], cap[4*k+2], cap[4*k+1], cap[4*k]};
      checks++;
      if (got !== b[k]) begin errors++; $display("FAIL clean_byte%0d: got %02h want %02h", k, got, b[k]); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL clean_done: got %0d want 1", ndone); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL clean_err: got %0b want 0", done_err); end
    checks++; if (done_cyc - last_oc !== 1) begin errors++; $display("FAIL clean_done_gap: got %0d want 1", done_cyc - last_oc); end
  endtask

  task automatic test_toggle_tail();
    int bad;
    for (int i = 0; i < 16; i++) exp_d[i] = 2'(i + (i / 4));
    gap(3);
    clr_mon();
    preamble(20);
    for (int i = 0; i < 12; i++) send(1'b1, exp_d[i]);
    send(1'b0, exp_d[12]);
    send(1'b1, exp_d[13]);
    send(1'b0, exp_d[14]);
    send(1'b1, exp_d[15]);
    gap(5);
    checks++; if (cnt !== 16) begin errors++; $display("FAIL toggle_count: got %0d want 16", cnt); end
    bad = -1;
    for (int i = 0; i < 16; i++) if (bad < 0 && cap[i] !== exp_d[i]) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL toggle_data: dibit %0d got %0h want %0h", bad, cap[bad], exp_d[bad]); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL toggle_done: got %0d want 1", ndone); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL toggle_err: got %0b want 0", done_err); end
  endtask

  task automatic test_short_preamble();
    gap(3);
    clr_mon();
    preamble(6);
    for (int i = 0; i < 8; i++) send(1'b1, 2'(i));
    gap(4);
    checks++; if (cnt !== 0) begin errors++; $display("FAIL short_count: got %0d want 0", cnt); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL short_done: got %0d want 0", ndone); end
    clr_mon();
    preamble(15);
    for (int i = 0; i < 8; i++) send(1'b1, 2'(3 - i));
    gap(4);
    checks++; if (cnt !== 8) begin errors++; $display("FAIL short_next_count: got %0d want 8", cnt); end
    checks++; if (cap[0] !== 2'd3 || cap[7] !== 2'd0) begin errors++; $display("FAIL short_next_data: got %0h/%0h want 3/0", cap[0], cap[7]); end
    checks++; if (ndone !== 1 || done_err !== 1'b0) begin errors++; $display("FAIL short_next_done: got %0d err %0b want 1 err 0", ndone, done_err); end
  endtask

  task automatic test_misaligned();
    gap(3);
    clr_mon();
    preamble(14);
    for (int i = 0; i < 30; i++) send(1'b1, 2'(i));
    gap(4);
    checks++; if (cnt !== 30) begin errors++; $display("FAIL misal_count: got %0d want 30", cnt); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL misal_done: got %0d want 1", ndone); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL misal_err: got %0b want 1", done_err); end
  endtask

  task automatic test_oversize();
    gap(3);
    clr_mon();
    preamble(14);
    for (int i = 0; i < 20; i++) send(1'b1, 2'(i));
    gap(4);
    checks++; if (cnt4 !== 16) begin errors++; $display("FAIL over_count: got %0d want 16", cnt4); end
    checks++; if (ndone4 !== 1) begin errors++; $display("FAIL over_done: got %0d want 1", ndone4); end
    checks++; if (done_err4 !== 1'b1) begin errors++; $display("FAIL over_err: got %0b want 1", done_err4); end
    checks++; if (done_cyc4 - last_oc4 !== 1) begin errors++; $display("FAIL over_done_gap: got %0d want 1", done_cyc4 - last_oc4); end
    checks++; if (cnt !== 20 || done_err !== 1'b0) begin errors++; $display("FAIL over_big_inst: got %0d err %0b want 20 err 0", cnt, done_err); end
  endtask

  task automatic test_reset_mid();
    gap(3);
    clr_mon();
    preamble(14);
    for (int i = 0; i < 10; i++) send(1'b1, 2'(i));
    @(negedge clk);
    reset = 1'b1;
    rxd   = 2'b10;
    @(negedge clk);
    checks++; if (outclk !== 1'b0 || out !== 2'b00) begin errors++; $display("FAIL rmid_out: got outclk %0b out %0h want 0/0", outclk, out); end
    checks++; if (done_out !== 1'b0 || ndone !== 0) begin errors++; $display("FAIL rmid_done: got %0b/%0d want 0/0", done_out, ndone); end
    reset = 1'b0;
    clr_mon();
    // Line still busy: a preamble-looking stream must not start a frame.
    repeat (14) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
    for (int i = 0; i < 6; i++) send(1'b1, 2'(i));
    gap(4);
    checks++; if (cnt !== 0 || ndone !== 0) begin errors++; $display("FAIL rmid_nocap: got %0d/%0d want 0/0", cnt, ndone); end
    clr_mon();
    preamble(14);
    for (int i = 0; i < 8; i++) send(1'b1, 2'(i));
    gap(4);
    checks++; if (cnt !== 8 || ndone !== 1 || done_err !== 1'b0) begin errors++; $display("FAIL rmid_next: got %0d/%0d/%0b want 8/1/0", cnt, ndone, done_err); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_toggle_tail();
    test_short_preamble();
    test_misaligned();
    test_oversize();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
